// File: rtl/sdft_bin_reader_if.sv
// Bundle between sdft_bin_reader and its neighbours: frame trigger, the
// addressed read port into the sdft bin store, and the (index, magnitude) stream.
interface sdft_bin_reader_if #(
  parameter int FREQ_BINS = 16,
  parameter int BIN_WIDTH = 12
);
  localparam int AW = $clog2(FREQ_BINS);

  logic                        start;
  logic [AW-1:0]               bin_addr;
  logic signed [BIN_WIDTH-1:0] bin_real;
  logic signed [BIN_WIDTH-1:0] bin_imag;
  logic                        out_valid;
  logic                        out_ready;
  logic [AW-1:0]               out_bin;
  logic [BIN_WIDTH:0]          out_mag;
  logic                        out_last;
  logic                        busy;
  logic                        overrun;

  modport master (
    input  start, bin_real, bin_imag, out_ready,
    output bin_addr, out_valid, out_bin, out_mag, out_last, busy, overrun
  );

  modport slave (
    output start, bin_real, bin_imag, out_ready,
    input  bin_addr, out_valid, out_bin, out_mag, out_last, busy, overrun
  );
endinterface

// File: rtl/sdft_bin_reader.sv
// Walks the sdft bin store on each frame trigger and streams (bin, |X| estimate)
// beats; one READ/OUTPUT pair per bin, magnitude = max + min/2.
module sdft_bin_reader #(
  parameter int DATA_WIDTH    = 8,
  parameter int FREQ_BINS     = 16,
  parameter int BIN_WIDTH     = DATA_WIDTH + $clog2(FREQ_BINS),
  parameter bit HALF_SPECTRUM = 1'b1
) (
  input logic                 clk_i,
  input logic                 rst_i,
  sdft_bin_reader_if.master   rd_io
);
  localparam int AW     = $clog2(FREQ_BINS);
  localparam int LAST_I = HALF_SPECTRUM ? FREQ_BINS / 2 : FREQ_BINS - 1;
  localparam logic [AW-1:0] LAST = LAST_I[AW-1:0];

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    READ   = 2'd1,
    OUTPUT = 2'd2
  } state_t;

  state_t             state_q;
  logic [AW-1:0]      addr_q;
  logic               valid_q;
  logic [AW-1:0]      bin_q;
  logic [BIN_WIDTH:0] mag_q;
  logic               last_q;
  logic               busy_q;
  logic               ovr_q;

  // One extra bit so |-2^(BIN_WIDTH-1)| is representable without wrapping.
  logic [BIN_WIDTH:0] re_x, im_x, abs_re, abs_im, mx, mn, mag_d;

  always_comb begin
    re_x   = {rd_io.bin_real[BIN_WIDTH-1], rd_io.bin_real};
    im_x   = {rd_io.bin_imag[BIN_WIDTH-1], rd_io.bin_imag};
    abs_re = re_x[BIN_WIDTH] ? -re_x : re_x;
    abs_im = im_x[BIN_WIDTH] ? -im_x : im_x;
    mx     = (abs_re >= abs_im) ? abs_re : abs_im;
    mn     = (abs_re >= abs_im) ? abs_im : abs_re;
    mag_d  = mx + (mn >> 1);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      addr_q  <= '0;
      valid_q <= 1'b0;
      bin_q   <= '0;
      mag_q   <= '0;
      last_q  <= 1'b0;
      busy_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      // A trigger during a frame is dropped, only flagged.
      ovr_q <= rd_io.start && busy_q;
      case (state_q)
        IDLE: begin
          if (rd_io.start) begin
            addr_q  <= '0;
            busy_q  <= 1'b1;
            state_q <= READ;
          end
        end
        READ: begin
          bin_q   <= addr_q;
          mag_q   <= mag_d;
          last_q  <= (addr_q == LAST);
          valid_q <= 1'b1;
          state_q <= OUTPUT;
        end
        OUTPUT: begin
          if (valid_q && rd_io.out_ready) begin
            valid_q <= 1'b0;
            if (last_q) begin
              busy_q  <= 1'b0;
              state_q <= IDLE;
            end else begin
              addr_q  <= addr_q + 1'b1;
              state_q <= READ;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rd_io.bin_addr  = addr_q;
  assign rd_io.out_valid = valid_q;
  assign rd_io.out_bin   = bin_q;
  assign rd_io.out_mag   = mag_q;
  assign rd_io.out_last  = last_q;
  assign rd_io.busy      = busy_q;
  assign rd_io.overrun   = ovr_q;
endmodule
